iob_dma_mc: RTL and testbench

IOB_DMA_MC -- requirements
Module: iob_dma_mc

---
 rtl/iob_dma_mc.sv | 168 ++++++++++++++++
 tb/tb_iob_dma_mc.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_dma_mc.sv
// rtl/iob_dma_mc.sv - multi-channel AXIS-to-memory write DMA with round-robin burst arbitration
module iob_dma_mc #(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int BURST_LEN = 8,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     cke_i,
  input  logic [CH_W-1:0]          cfg_ch_i,
  input  logic [ADDR_W-1:0]        cfg_base_i,
  input  logic [LEN_W-1:0]         cfg_len_i,
  input  logic                     cfg_start_i,
  input  logic [N_CH-1:0]          done_clr_i,
  output logic [N_CH-1:0]          busy_o,
  output logic [N_CH-1:0]          done_o,
  output logic                     irq_o,
  input  logic [N_CH*DATA_W-1:0]   tdata_i,
  input  logic [N_CH-1:0]          tvalid_i,
  output logic [N_CH-1:0]          tready_o,
  output logic                     mem_valid_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_data_o,
  input  logic                     mem_ready_i
);

  localparam int BC_W  = $clog2(BURST_LEN + 1);
  localparam int BYTES = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_XFER
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q [N_CH];
  logic [LEN_W-1:0]  len_q  [N_CH];
  logic [LEN_W-1:0]  cnt_q  [N_CH];
  logic [N_CH-1:0]   busy_q;
  logic [N_CH-1:0]   done_q;
  logic [N_CH-1:0]   start_acc;
  logic [N_CH-1:0]   req;
  logic [CH_W-1:0]   g_q;
  logic [CH_W-1:0]   win;
  logic              win_found;
  logic [BC_W-1:0]   bc_q;
  logic              beat;
  logic              last_word;
  logic              burst_end;

  // A channel requests service only while armed and offering data.
  assign req       = busy_q & tvalid_i;
  assign beat      = (state == S_XFER) && tvalid_i[g_q] && mem_ready_i;
  assign last_word = (cnt_q[g_q] + LEN_W'(1)) == len_q[g_q];
  assign burst_end = (bc_q + BC_W'(1)) == BC_W'(BURST_LEN);

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign irq_o  = |done_q;

  // Accept a start only for an existing, idle channel; out-of-range selects match no k.
  always_comb begin
    start_acc = '0;
    for (int k = 0; k < N_CH; k++) begin
      start_acc[k] = cfg_start_i && (cfg_ch_i == CH_W'(k)) && !busy_q[k];
    end
  end

  // Round-robin winner search starting just after the last granted channel.
  always_comb begin
    win       = g_q;
    win_found = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      if (!win_found && req[(int'(g_q) + i) % N_CH]) begin
        win_found = 1'b1;
        win       = CH_W'((int'(g_q) + i) % N_CH);
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= S_IDLE;
    end else if (cke_i) begin
      state <= state_nxt;
    end
  end

  // Arbiter next-state: one GRANT cycle, then stream until burst or transfer ends.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_GRANT;
      S_GRANT: state_nxt = S_XFER;
      S_XFER: begin
        if (!busy_q[g_q] || (beat && (last_word || burst_end))) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant pointer doubles as the round-robin "last grant"; burst counter restarts per grant.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      g_q  <= CH_W'(N_CH - 1);
      bc_q <= '0;
    end else if (cke_i) begin
      if (state == S_IDLE && win_found) g_q <= win;
      if (state == S_GRANT) begin
        bc_q <= '0;
      end else if (beat) begin
        bc_q <= bc_q + BC_W'(1);
      end
    end
  end

  // Per-channel descriptor, progress and flags; a completion outranks a same-cycle clear.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      busy_q <= '0;
      done_q <= '0;
      for (int k = 0; k < N_CH; k++) begin
        base_q[k] <= '0;
        len_q[k]  <= '0;
        cnt_q[k]  <= '0;
      end
    end else if (cke_i) begin
      for (int k = 0; k < N_CH; k++) begin
        if (done_clr_i[k]) done_q[k] <= 1'b0;
        if (start_acc[k]) begin
          base_q[k] <= cfg_base_i;
          len_q[k]  <= cfg_len_i;
          cnt_q[k]  <= '0;
          busy_q[k] <= (cfg_len_i != '0);
          done_q[k] <= (cfg_len_i == '0);
        end
        if (beat && (g_q == CH_W'(k))) begin
          cnt_q[k] <= cnt_q[k] + LEN_W'(1);
          if (last_word) begin
            busy_q[k] <= 1'b0;
            done_q[k] <= 1'b1;
          end
        end
      end
    end
  end

  // Combinational pass-through from the granted stream to the memory port.
  always_comb begin
    mem_valid_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    tready_o    = '0;
    if (state == S_XFER) begin
      mem_valid_o   = tvalid_i[g_q];
      mem_data_o    = tdata_i[int'(g_q) * DATA_W +: DATA_W];
      mem_addr_o    = base_q[g_q] + ADDR_W'(cnt_q[g_q]) * ADDR_W'(BYTES);
      tready_o[g_q] = mem_ready_i;
    end
  end

endmodule

// File: tb/tb_iob_dma_mc.sv
// tb/tb_iob_dma_mc.sv - self-checking bench for iob_dma_mc against a queue-based transfer model
module tb_iob_dma_mc;

  localparam int N_CH      = 4;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int LEN_W     = 16;
  localparam int BURST_LEN = 8;
  localparam int CH_W      = 2;

  logic                   clk_i = 1'b0;
  logic                   arst_i;
  logic                   cke_i;
  logic [CH_W-1:0]        cfg_ch_i;
  logic [ADDR_W-1:0]      cfg_base_i;
  logic [LEN_W-1:0]       cfg_len_i;
  logic                   cfg_start_i;
  logic [N_CH-1:0]        done_clr_i;
  logic [N_CH-1:0]        busy_o;
  logic [N_CH-1:0]        done_o;
  logic                   irq_o;
  logic [N_CH*DATA_W-1:0] tdata_i;
  logic [N_CH-1:0]        tvalid_i;
  logic [N_CH-1:0]        tready_o;
  logic                   mem_valid_o;
  logic [ADDR_W-1:0]      mem_addr_o;
  logic [DATA_W-1:0]      mem_data_o;
  logic                   mem_ready_i;

  always #5 clk_i = ~clk_i;

  iob_dma_mc #(
    .N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i),
    .cfg_ch_i(cfg_ch_i), .cfg_base_i(cfg_base_i), .cfg_len_i(cfg_len_i), .cfg_start_i(cfg_start_i),
    .done_clr_i(done_clr_i), .busy_o(busy_o), .done_o(done_o), .irq_o(irq_o),
    .tdata_i(tdata_i), .tvalid_i(tvalid_i), .tready_o(tready_o),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ready_i(mem_ready_i)
  );

  typedef struct {
    int                ch;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } beat_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: each armed channel owns the list of writes it still owes, in order.
  logic [ADDR_W-1:0] exp_addr [N_CH][$];
  logic [DATA_W-1:0] exp_data [N_CH][$];
  logic [DATA_W-1:0] src_q    [N_CH][$];
  logic [N_CH-1:0]   m_done;
  logic [N_CH-1:0]   hold;
  logic              stalled_prev;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;
  bit                src_en, gap_mode, bp_mode;
  beat_t             log_q[$];

  function automatic logic [N_CH-1:0] m_busy();
    logic [N_CH-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k] = (exp_addr[k].size() != 0);
    return r;
  endfunction

  function automatic int count_ch(int c);
    int n = 0;
    foreach (log_q[i]) if (log_q[i].ch == c) n++;
    return n;
  endfunction

  // One clock: compare flags, fold this cycle's events into the model, drive next inputs.
  task automatic step();
    logic [N_CH-1:0] mb;
    logic [N_CH-1:0] fin;
    logic [N_CH-1:0] set0;
    int ch;
    beat_t b;
    @(negedge clk_i);
    cyc++;
    mb = m_busy();
    total++; if (busy_o !== mb) begin bad++; $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy_o, mb); end
    total++; if (done_o !== m_done) begin bad++; $display("FAIL done cyc=%0d got=%b want=%b", cyc, done_o, m_done); end
    total++; if (irq_o !== (|m_done)) begin bad++; $display("FAIL irq cyc=%0d got=%b want=%b", cyc, irq_o, |m_done); end
    total++; if (mem_valid_o && (mb == '0)) begin bad++; $display("FAIL stray_write cyc=%0d got=1 want=0", cyc); end
    total++; if (!mem_ready_i && (tready_o !== '0)) begin bad++; $display("FAIL tready_no_ready cyc=%0d got=%b want=0", cyc, tready_o); end
    if (stalled_prev && mem_valid_o) begin
      total++;
      if (mem_addr_o !== prev_addr || mem_data_o !== prev_data) begin
        bad++; $display("FAIL stall_hold cyc=%0d got=%h/%h want=%h/%h", cyc, mem_addr_o, mem_data_o, prev_addr, prev_data);
      end
    end
    fin  = '0;
    set0 = '0;
    if (cfg_start_i && cke_i && (int'(cfg_ch_i) < N_CH) && !mb[cfg_ch_i]) begin
      ch = int'(cfg_ch_i);
      m_done[ch] = (cfg_len_i == '0);
      set0[ch]   = (cfg_len_i == '0);
      for (int i = 0; i < int'(cfg_len_i); i++) begin
        logic [DATA_W-1:0] d;
        d = $urandom;
        exp_addr[ch].push_back(cfg_base_i + ADDR_W'(i * (DATA_W / 8)));
        exp_data[ch].push_back(d);
        src_q[ch].push_back(d);
      end
    end
    if (mem_valid_o && mem_ready_i && cke_i) begin
      total++;
      if ($countones(tready_o) != 1) begin
        bad++; $display("FAIL tready_onehot cyc=%0d got=%b want=onehot", cyc, tready_o);
      end else begin
        ch = 0;
        for (int k = 0; k < N_CH; k++) if (tready_o[k]) ch = k;
        total++;
        if (exp_addr[ch].size() == 0) begin
          bad++; $display("FAIL unexpected_write cyc=%0d ch=%0d addr=%h", cyc, ch, mem_addr_o);
        end else begin
          total++;
          if (mem_addr_o !== exp_addr[ch][0] || mem_data_o !== exp_data[ch][0]) begin
            bad++; $display("FAIL write ch=%0d cyc=%0d got=%h/%h want=%h/%h", ch, cyc,
                            mem_addr_o, mem_data_o, exp_addr[ch][0], exp_data[ch][0]);
          end
          void'(exp_addr[ch].pop_front());
          void'(exp_data[ch].pop_front());
          if (exp_addr[ch].size() == 0) begin
            m_done[ch] = 1'b1;
            fin[ch]    = 1'b1;
          end
          b.ch = ch; b.addr = mem_addr_o; b.data = mem_data_o; b.cyc = cyc;
          log_q.push_back(b);
        end
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      if (done_clr_i[k] && cke_i && !fin[k] && !set0[k]) m_done[k] = 1'b0;
      if (tvalid_i[k] && tready_o[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      hold[k] = tvalid_i[k] && !tready_o[k];
    end
    stalled_prev = mem_valid_o && !mem_ready_i;
    prev_addr    = mem_addr_o;
    prev_data    = mem_data_o;
    @(posedge clk_i);
    #1;
    for (int k = 0; k < N_CH; k++) begin
      if (src_en && src_q[k].size() > 0 && (hold[k] || !gap_mode || $urandom_range(0, 2) != 0)) begin
        tvalid_i[k] = 1'b1;
        tdata_i[k*DATA_W +: DATA_W] = src_q[k][0];
      end else begin
        tvalid_i[k] = 1'b0;
        tdata_i[k*DATA_W +: DATA_W] = $urandom;
      end
    end
    mem_ready_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic cfg(input int ch, input logic [ADDR_W-1:0] base, input int len);
    cfg_ch_i    = CH_W'(ch);
    cfg_base_i  = base;
    cfg_len_i   = LEN_W'(len);
    cfg_start_i = 1'b1;
    step();
    cfg_start_i = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (m_busy() != '0 && n < max) begin step(); n++; end
    total++;
    if (m_busy() != '0) begin bad++; $display("FAIL drain_timeout got=%b want=0", m_busy()); end
    step();
    step();
  endtask

  task automatic do_reset();
    arst_i      = 1'b1;
    tvalid_i    = '0;
    cfg_start_i = 1'b0;
    done_clr_i  = '0;
    mem_ready_i = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      exp_addr[k].delete(); exp_data[k].delete(); src_q[k].delete();
    end
    m_done = '0; hold = '0; stalled_prev = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    arst_i = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (busy_o !== '0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_o); end
    total++; if (done_o !== '0) begin bad++; $display("FAIL rst_done got=%b want=0", done_o); end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", irq_o); end
    total++; if (tready_o !== '0) begin bad++; $display("FAIL rst_tready got=%b want=0", tready_o); end
    total++; if (mem_valid_o !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%b want=0", mem_valid_o); end
    do_reset();
    step();
  endtask

  task automatic test_single();
    logic [ADDR_W-1:0] ea [4];
    ea = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    do_reset();
    src_en = 1; gap_mode = 0; bp_mode = 0;
    log_q.delete();
    cfg(0, 32'h1000, 4);
    drain(50);
    total++;
    if (log_q.size() != 4) begin
      bad++; $display("FAIL single_count got=%0d want=4", log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (log_q[i].addr !== ea[i]) begin bad++; $display("FAIL single_addr%0d got=%h want=%h", i, log_q[i].addr, ea[i]); end
      end
    end
    total++; if (done_o[0] !== 1'b1) begin bad++; $display("FAIL single_done got=%b want=1", done_o[0]); end
    total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL single_irq got=%b want=1", irq_o); end
  endtask

  task automatic test_round_robin();
    int run_ch[$], run_n[$], run_first[$], run_last[$];
    int want_ch[4], want_n[4];
    want_ch = '{0, 2, 0, 2};
    want_n  = '{8, 8, 2, 2};
    do_reset();
    src_en = 0; gap_mode = 0; bp_mode = 0;
    cfg(0, 32'h0000_0100, 10);
    cfg(2, 32'h0000_8000, 10);
    src_en = 1;
    log_q.delete();
    drain(200);
    foreach (log_q[i]) begin
      if (run_ch.size() == 0 || run_ch[$] != log_q[i].ch) begin
        run_ch.push_back(log_q[i].ch); run_n.push_back(1);
        run_first.push_back(log_q[i].cyc); run_last.push_back(log_q[i].cyc);
      end else begin
        run_n[$] = run_n[$] + 1;
        run_last[$] = log_q[i].cyc;
      end
    end
    total++;
    if (run_ch.size() != 4) begin
      bad++; $display("FAIL rr_runs got=%0d want=4", run_ch.size());
    end else begin
      for (int r = 0; r < 4; r++) begin
        total++;
        if (run_ch[r] != want_ch[r] || run_n[r] != want_n[r]) begin
          bad++; $display("FAIL rr_run%0d got=ch%0d x%0d want=ch%0d x%0d", r, run_ch[r], run_n[r], want_ch[r], want_n[r]);
        end
        total++;
        if (run_last[r] - run_first[r] + 1 != run_n[r]) begin
          bad++; $display("FAIL rr_contig%0d got=%0d want=%0d", r, run_last[r] - run_first[r] + 1, run_n[r]);
        end
        if (r < 3) begin
          total++;
          if (run_first[r+1] - run_last[r] != 3) begin
            bad++; $display("FAIL rr_gap%0d got=%0d want=3", r, run_first[r+1] - run_last[r]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    src_en = 1; gap_mode = 1; bp_mode = 1;
    log_q.delete();
    cfg(1, 32'h0000_4000, 12);
    cfg(3, 32'h0000_6000, 5);
    drain(1000);
    gap_mode = 0; bp_mode = 0;
    step();
    total++; if (count_ch(1) != 12) begin bad++; $display("FAIL bp_ch1_words got=%0d want=12", count_ch(1)); end
    total++; if (count_ch(3) != 5) begin bad++; $display("FAIL bp_ch3_words got=%0d want=5", count_ch(3)); end
    total++; if (done_o[1] !== 1'b1 || done_o[3] !== 1'b1) begin bad++; $display("FAIL bp_done got=%b want=1x1x", done_o); end
  endtask

  task automatic test_edges();
    done_clr_i = '1; step(); done_clr_i = '0;
    cfg(2, 32'h0000_0300, 0);
    total++; if (done_o[2] !== 1'b1) begin bad++; $display("FAIL len0_done got=%b want=1", done_o[2]); end
    total++; if (busy_o[2] !== 1'b0) begin bad++; $display("FAIL len0_busy got=%b want=0", busy_o[2]); end
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_valid_o !== 1'b0) begin bad++; $display("FAIL len0_mem_valid got=%b want=0", mem_valid_o); end
      step();
    end
    src_en = 0;
    log_q.delete();
    cfg(0, 32'h0000_2000, 6);
    cfg(0, 32'h0000_5000, 3);
    src_en = 1;
    drain(100);
    total++;
    if (log_q.size() != 6 || log_q[0].addr !== 32'h2000 || log_q[5].addr !== 32'h2014) begin
      bad++; $display("FAIL busy_restart got=%0d words want=6 from 2000 to 2014", log_q.size());
    end
    log_q.delete();
    cfg(3, 32'hFFFF_FFFC, 2);
    drain(50);
    total++;
    if (log_q.size() != 2 || log_q[0].addr !== 32'hFFFF_FFFC || log_q[1].addr !== 32'h0) begin
      bad++; $display("FAIL wrap got=%0d words want=2 at fffffffc,00000000", log_q.size());
    end
    cke_i = 1'b0;
    cfg(1, 32'h0000_0010, 2);
    cke_i = 1'b1;
    step();
    total++; if (busy_o[1] !== 1'b0) begin bad++; $display("FAIL cke_freeze got=%b want=0", busy_o[1]); end
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    do_reset();
    src_en = 1; gap_mode = 0; bp_mode = 0;
    log_q.delete();
    cfg(0, 32'h0000_7000, 8);
    while (count_ch(0) < 3 && n < 50) begin step(); n++; end
    total++; if (count_ch(0) != 3) begin bad++; $display("FAIL mid_wait got=%0d want=3", count_ch(0)); end
    total++; if (mem_valid_o !== 1'b1) begin bad++; $display("FAIL mid_active got=%b want=1", mem_valid_o); end
    arst_i = 1'b1;
    #1;
    total++; if (mem_valid_o !== 1'b0) begin bad++; $display("FAIL mid_mem_valid got=%b want=0", mem_valid_o); end
    total++; if (busy_o !== '0 || done_o !== '0) begin bad++; $display("FAIL mid_flags got=%b/%b want=0/0", busy_o, done_o); end
    total++; if (tready_o !== '0) begin bad++; $display("FAIL mid_tready got=%b want=0", tready_o); end
    do_reset();
    src_en = 0;
    log_q.delete();
    cfg(3, 32'h0000_A000, 2);
    cfg(1, 32'h0000_B000, 2);
    src_en = 1;
    drain(100);
    total++;
    if (log_q.size() == 0 || log_q[0].ch != 1) begin
      bad++; $display("FAIL mid_first_grant got=%0d want=1", (log_q.size() == 0) ? -1 : log_q[0].ch);
    end
  endtask

  task automatic test_done_race();
    int n = 0;
    src_en = 1; gap_mode = 0; bp_mode = 0;
    done_clr_i = '1; step(); done_clr_i = '0;
    cfg(1, 32'h0000_C000, 3);
    while (exp_addr[1].size() != 1 && n < 50) begin step(); n++; end
    total++; if (exp_addr[1].size() != 1) begin bad++; $display("FAIL race_wait got=%0d want=1", exp_addr[1].size()); end
    done_clr_i  = 4'b0010;
    cfg_ch_i    = 2'd2;
    cfg_len_i   = '0;
    cfg_start_i = 1'b1;
    step();
    cfg_start_i = 1'b0;
    done_clr_i  = '0;
    total++; if (done_o[1] !== 1'b1) begin bad++; $display("FAIL race_set_wins got=%b want=1", done_o[1]); end
    total++; if (done_o[2] !== 1'b1) begin bad++; $display("FAIL race_indep_start got=%b want=1", done_o[2]); end
    done_clr_i = 4'b0110;
    step();
    done_clr_i = '0;
    total++; if (done_o[1] !== 1'b0) begin bad++; $display("FAIL race_late_clr got=%b want=0", done_o[1]); end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL race_irq got=%b want=0", irq_o); end
    step();
  endtask

  initial begin
    arst_i = 1'b1; cke_i = 1'b1;
    cfg_ch_i = '0; cfg_base_i = '0; cfg_len_i = '0; cfg_start_i = 1'b0;
    done_clr_i = '0; tdata_i = '0; tvalid_i = '0; mem_ready_i = 1'b1;
    m_done = '0; hold = '0; stalled_prev = 1'b0; prev_addr = '0; prev_data = '0;
    src_en = 0; gap_mode = 0; bp_mode = 0;
    @(posedge clk_i); #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_edges();
    test_reset_mid_burst();
    test_done_race();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
